prog_mem_ctrl: RTL
==================

Name: prog_mem_ctrl

Overview:
Parametrised program memory for the 14-bit-instruction core; it replaces the fixed combinational program ROM.
- Holds an inferred synchronous RAM of DEPTH words.
- Filled at boot through a valid/ready load stream, then serves instruction fetches with 1-cycle registered latency.
- Tracks a running checksum and word count so the boot controller can validate the image before releasing the core.

Parameters:
DATA_W, 14, instruction word width
ADDR_W, 11, fetch/load address width
DEPTH, 2048, implemented words; must be <= 2**ADDR_W
NOP_WORD, 14'h0000, word returned for unloaded, out-of-range or blocked fetches
CSUM_W, 16, checksum accumulator width; must be >= DATA_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin a new image load; clears count/checksum
load_valid  in  1  load word present
load_data  in  DATA_W  load word
load_last  in  1  qualifies final word of image
load_ready  out  1  block accepts load word this cycle
load_done  out  1  image complete, memory in RUN
load_err  out  1  sticky overflow error
load_count  out  ADDR_W+1  words written in current image
checksum  out  CSUM_W  modular sum of words written
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_W  program counter
fetch_data  out  DATA_W  instruction, valid the cycle after request
fetch_valid  out  1  fetch_data carries a real memory word

Behaviour:
Reset (async assert, sync release):
- state=EMPTY; load_ready=0, load_done=0, load_err=0, load_count=0, checksum=0.
- fetch_data=NOP_WORD, fetch_valid=0.
- Memory contents are not reset.

FSM states: EMPTY, LOADING, RUN, ERROR.
- EMPTY --load_start--> LOADING.
- LOADING --accepted word with load_last--> RUN.
- LOADING --accepted word when load_count==DEPTH--> ERROR. That word is not written.
- RUN --load_start--> LOADING (reload).
- ERROR --load_start--> LOADING.
- load_start in any state: clears load_count, checksum and load_err; takes priority over a simultaneous load_valid, which is ignored that cycle.

Load:
- load_ready=1 only in LOADING. Handshake is load_valid&&load_ready.
- On a handshake: mem[load_count]<=load_data; load_count+=1; checksum<=checksum+zero-extended load_data, mod 2**CSUM_W.
- A handshake with load_last writes the word, updates count/checksum, then enters RUN. load_done=1 from the next cycle until the next load_start.
- In ERROR: load_err=1 and load_ready=0. count/checksum freeze at the overflow point.
- Minimum image length is 1 word. Words not written keep stale contents.

Fetch:
- Registered, latency 1. Response at cycle N+1 to a fetch_en at cycle N:
  - RUN and fetch_addr<DEPTH: fetch_data=mem[fetch_addr], fetch_valid=1.
  - RUN and fetch_addr>=DEPTH: fetch_data=NOP_WORD, fetch_valid=1.
  - Not RUN: fetch_data=NOP_WORD, fetch_valid=0.
- fetch_en=0: fetch_data holds its previous value; fetch_valid=0.
- Back-to-back fetches sustain 1 word/cycle.

Simultaneous load/fetch:
- A fetch issued in the cycle the last word is accepted sees state LOADING, so it returns NOP_WORD with valid=0.
- On load_start during RUN, a fetch issued that same cycle still completes normally. Fetches issued afterwards return NOP_WORD.

Reset mid-load: state returns to EMPTY, count/checksum clear, partially written words remain in memory.

Decomposition:
Shared package prog_mem_pkg:
- typedef pm_state_e {EMPTY, LOADING, RUN, ERROR}
- default DATA_W/ADDR_W/CSUM_W constants
- NOP_WORD constant

One sub-module: prog_mem_ram.
- Single-port-write, single-port-read synchronous RAM with no reset, so it infers block RAM.
- Holds the storage array only; FSM, counters and checksum stay in prog_mem_ctrl.

Test Plan:
- Reset, then fetch_en at addr 0 -> fetch_valid=0, fetch_data=14'h0000; load_ready=0.
- load_start; stream 3003,01A5,000B with last on 000B -> load_count=3, checksum=16'h31B3, load_done=1; fetches of addr 0,1,2 back-to-back return 3003,01A5,000B on consecutive cycles, each with valid=1.
- DEPTH=4 build: stream 5 words, no last -> after 4th word the 5th handshake sets load_err=1; state ERROR, load_ready=0, load_count=4, mem[0..3] intact.
- In RUN, fetch addr 4 with DEPTH=4 (ADDR_W=3) -> fetch_data=NOP_WORD, valid=1.
- In RUN, load_start together with load_valid -> word ignored, count=0, checksum=0, load_done=0. A fetch issued that cycle returns the old word with valid=1; the next fetch returns NOP with valid=0.
- Assert rst_n low mid-load after 2 words -> outputs return to reset values immediately. Reload with 1 word plus last -> load_done=1, count=1.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared types and default constants for the program memory controller.
package prog_mem_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int ADDR_W_DEF = 11;
    localparam int CSUM_W_DEF = 16;
    localparam int DEPTH_DEF  = 2048;

    // Word handed to the core when no real instruction is available.
    localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = 14'h0000;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        RUN     = 2'd2,
        ERROR   = 2'd3
    } pm_state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// Storage array for the program memory: one write port, one registered
// read port, no reset so the tools map it onto block RAM.
module prog_mem_ram #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 2048,
    parameter int AW     = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Write on request; read register only updates on a read so it holds otherwise.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: boot-time load stream with overflow detection,
// running word count and checksum, and 1-cycle registered instruction fetch.
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
    parameter int                CSUM_W   = CSUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count,
    output logic [CSUM_W-1:0] checksum,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid
);

    localparam int              RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    pm_state_e         state_reg, state_next;
    logic [ADDR_W:0]   count_reg;
    logic [CSUM_W-1:0] csum_reg;
    logic              accept;
    logic              overflow;
    logic              wr_en;
    logic              rd_en;
    logic              fetch_valid_reg;
    logic              src_mem_reg;
    logic [DATA_W-1:0] ram_rd_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and status outputs; load_start overrides everything else.
    always_comb begin
        state_next = state_reg;
        load_ready = 1'b0;
        load_done  = 1'b0;
        load_err   = 1'b0;
        accept     = 1'b0;
        overflow   = 1'b0;
        case (state_reg)
            EMPTY: begin
            end
            LOADING: begin
                load_ready = 1'b1;
                accept     = load_valid && !load_start;
                if (accept) begin
                    if (count_reg == DEPTH_CNT) begin
                        overflow   = 1'b1;
                        state_next = ERROR;
                    end else if (load_last) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                load_done = 1'b1;
            end
            ERROR: begin
                load_err = 1'b1;
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        if (load_start) begin
            state_next = LOADING;
        end
    end

    // The overflowing word is dropped, so count/checksum freeze at DEPTH.
    assign wr_en = accept && !overflow;

    // Word count and modular checksum of the current image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            csum_reg  <= '0;
        end else if (load_start) begin
            count_reg <= '0;
            csum_reg  <= '0;
        end else if (wr_en) begin
            count_reg <= count_reg + (ADDR_W+1)'(1);
            csum_reg  <= csum_reg + CSUM_W'(load_data);
        end
    end

    assign load_count = count_reg;
    assign checksum   = csum_reg;

    // Only in-range fetches in RUN touch the RAM read register.
    assign rd_en = fetch_en && (state_reg == RUN) && ({1'b0, fetch_addr} < DEPTH_CNT);

    // Fetch response flags; src_mem_reg picks RAM data vs NOP and holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_reg <= 1'b0;
            src_mem_reg     <= 1'b0;
        end else begin
            fetch_valid_reg <= fetch_en && (state_reg == RUN);
            if (fetch_en) begin
                src_mem_reg <= rd_en;
            end
        end
    end

    assign fetch_valid = fetch_valid_reg;
    assign fetch_data  = src_mem_reg ? ram_rd_data : NOP_WORD;

    prog_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count_reg[RAM_AW-1:0]),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (fetch_addr[RAM_AW-1:0]),
        .rd_data (ram_rd_data)
    );

endmodule
